// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide unit with architectural HI/LO registers
// Ports: clk, rst (async, active high); start/op/a/b launch an operation from IDLE;
//   hi_we/lo_we/wdata perform mthi/mtlo while IDLE; busy/done form the stall handshake;
//   div_by_zero is sticky until the next accepted start; hi/lo are the architectural registers.
// Optional: define MULDIV_EARLY_TERM_EN to end multiplies once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE = 2'd0, PREP = 2'd1, RUN = 2'd2, FIX = 2'd3;
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic               sa, sb;
    // mult: acc = partial product, opb = shifted multiplicand, mq = remaining multiplier
    // div:  acc = {remainder, dividend/quotient}, opb[WIDTH-1:0] = divisor
    logic [2*WIDTH-1:0] acc, opb, prod_fix;
    logic [WIDTH-1:0]   mq, ma, mb, q_fix, r_fix, dvd_fix;
    logic [WIDTH:0]     diff;
    logic               neg, dz, last;
    assign busy     = state != IDLE;
    assign ma       = (!op[0] && a[WIDTH-1]) ? -a : a;
    assign mb       = (!op[0] && b[WIDTH-1]) ? -b : b;
    assign diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb[WIDTH-1:0]};
    assign neg      = sa ^ sb;
    assign dz       = op_q[1] && opb[WIDTH-1:0] == '0;
    assign prod_fix = neg ? -acc : acc;
    assign q_fix    = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix    = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    // divide-by-zero skips RUN, so the dividend magnitude is still intact in acc
    assign dvd_fix  = sa ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
`ifdef MULDIV_EARLY_TERM_EN
    assign last = cnt == CNT_W'(1) || (!op_q[1] && mq[WIDTH-1:1] == '0);
`else
    assign last = cnt == CNT_W'(1);
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            acc         <= '0;
            opb         <= '0;
            mq          <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state       <= PREP;
                        op_q        <= op;
                        sa          <= !op[0] && a[WIDTH-1];
                        sb          <= !op[0] && b[WIDTH-1];
                        div_by_zero <= 1'b0;
                        acc         <= op[1] ? {{WIDTH{1'b0}}, ma} : '0;
                        opb         <= {{WIDTH{1'b0}}, op[1] ? mb : ma};
                        mq          <= mb;
                    end
                end
                PREP: begin
                    state <= dz ? FIX : RUN;
                    cnt   <= CNT_W'(WIDTH);
                end
                RUN: begin
                    cnt   <= cnt - 1'b1;
                    state <= last ? FIX : RUN;
                    if (op_q[1])
                        acc <= diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                           : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                    else begin
                        acc <= acc + (mq[0] ? opb : '0);
                        opb <= opb << 1;
                        mq  <= mq >> 1;
                    end
                end
                FIX: begin
                    state       <= IDLE;
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    {hi, lo}    <= !op_q[1] ? prod_fix
                                 : dz       ? {dvd_fix, {WIDTH{1'b1}}}
                                 :            {r_fix, q_fix};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic        clk, rst, start, hi_we, lo_we, busy, done, div_by_zero;
    logic [1:0]  op;
    logic [31:0] a, b, wdata, hi, lo;
    int tests = 0, fails = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bit_len(input logic [31:0] m);
        int n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n;
    endfunction

    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic ez, output int lat);
        longint sp;
        logic [63:0] up;
        int sx, sy;
        logic [31:0] my;
        ez = 1'b0;
        lat = 34;
        sx = x;
        sy = y;
        if (!o[1]) begin
            if (o[0]) begin
                up = {32'd0, x} * {32'd0, y};
                {eh, el} = up;
            end else begin
                sp = longint'(sx) * longint'(sy);
                {eh, el} = sp;
            end
`ifdef MULDIV_EARLY_TERM_EN
            my = (!o[0] && y[31]) ? -y : y;
            lat = 2 + ((bit_len(my) < 1) ? 1 : bit_len(my));
`endif
        end else if (y == 0) begin
            eh = x;
            el = 32'hFFFF_FFFF;
            ez = 1'b1;
            lat = 2;
        end else if (o[0]) begin
            el = x / y;
            eh = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            el = x;
            eh = 32'd0;
        end else begin
            el = sx / sy;
            eh = sx % sy;
        end
    endfunction

    // Starts an operation in the current cycle, scrambles the operand inputs right after
    // they are sampled, and waits (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int busy_bad, output logic dz0);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        dz0 = div_by_zero;
        lat = 0;
        busy_bad = 0;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL reset_hilo got %h exp 0", {hi, lo}); end
        tests++; if ({busy, done, div_by_zero} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {busy, done, div_by_zero}); end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_idle got %b exp 00", {busy, done}); end
    endtask

    task automatic test_mult;
        int lat, bb, el_lat;
        logic dz0, ez;
        logic [31:0] eh, el;
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, lat, bb, dz0);
        model(2'b00, 32'd7, 32'hFFFF_FFFD, eh, el, ez, el_lat);
        tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin fails++; $display("FAIL mult_neg got %h exp ffffffffffffffeb", {hi, lo}); end
        tests++; if (lat !== el_lat) begin fails++; $display("FAIL mult_latency got %0d exp %0d", lat, el_lat); end
        tests++; if (bb !== 0) begin fails++; $display("FAIL mult_busy got %0d bad cycles exp 0", bb); end
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bb, dz0);
        tests++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL multu_max got %h exp fffffffe00000001", {hi, lo}); end
        tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL multu_dbz got %b exp 0", div_by_zero); end
        run_op(2'b00, 32'd9, 32'd1, lat, bb, dz0);
`ifdef MULDIV_EARLY_TERM_EN
        el_lat = 3;
`else
        el_lat = 34;
`endif
        tests++; if ({hi, lo} !== 64'd9) begin fails++; $display("FAIL mult_9x1 got %h exp 9", {hi, lo}); end
        tests++; if (lat !== el_lat) begin fails++; $display("FAIL mult_9x1_latency got %0d exp %0d", lat, el_lat); end
    endtask

    task automatic test_div;
        int lat, bb;
        logic dz0;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bb, dz0);
        tests++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin fails++; $display("FAIL div_neg7 got %h exp fffffffffffffffd", {hi, lo}); end
        tests++; if (lat !== 34) begin fails++; $display("FAIL div_latency got %0d exp 34", lat); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bb, dz0);
        tests++; if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin fails++; $display("FAIL div_min_m1 got %h exp 0000000080000000", {hi, lo}); end
    endtask

    task automatic test_div_zero;
        int lat, bb;
        logic dz0;
        run_op(2'b11, 32'd5, 32'd0, lat, bb, dz0);
        tests++; if (lat !== 2) begin fails++; $display("FAIL dbz_latency got %0d exp 2", lat); end
        tests++; if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF}) begin fails++; $display("FAIL dbz_result got %h exp 00000005ffffffff", {hi, lo}); end
        tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_flag got %b exp 1", div_by_zero); end
        repeat (3) @(posedge clk);
        #1;
        tests++; if (div_by_zero !== 1'b1) begin fails++; $display("FAIL dbz_sticky got %b exp 1", div_by_zero); end
        run_op(2'b01, 32'd2, 32'd3, lat, bb, dz0);
        tests++; if (dz0 !== 1'b0) begin fails++; $display("FAIL dbz_clear got %b exp 0", dz0); end
        tests++; if ({hi, lo} !== 64'd6) begin fails++; $display("FAIL multu_2x3 got %h exp 6", {hi, lo}); end
        run_op(2'b10, 32'hFFFF_FFF6, 32'd0, lat, bb, dz0);
        tests++; if ({hi, lo, div_by_zero} !== {32'hFFFF_FFF6, 32'hFFFF_FFFF, 1'b1}) begin fails++; $display("FAIL dbz_signed got %h exp fffffff6ffffffff1", {hi, lo, div_by_zero}); end
    endtask

    task automatic test_mthi_mtlo;
        int dones = 0;
        lo_we = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        lo_we = 1'b0;
        tests++; if (lo !== 32'h1234) begin fails++; $display("FAIL mtlo got %h exp 00001234", lo); end
        hi_we = 1'b1; wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        hi_we = 1'b0;
        tests++; if (hi !== 32'hAAAA_5555) begin fails++; $display("FAIL mthi got %h exp aaaa5555", hi); end
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5; lo_we = 1'b1; wdata = 32'h77;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        tests++; if (lo !== 32'h77) begin fails++; $display("FAIL mtlo_with_start got %h exp 00000077", lo); end
        repeat (4) @(posedge clk);
        #1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        tests++; if (hi !== 32'hAAAA_5555) begin fails++; $display("FAIL mthi_busy got %h exp aaaa5555", hi); end
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        tests++; if (dones !== 1) begin fails++; $display("FAIL busy_start_dones got %0d exp 1", dones); end
        tests++; if ({hi, lo, div_by_zero} !== {64'd15, 1'b0}) begin fails++; $display("FAIL mult_3x5 got %h exp 0000000000000000f0", {hi, lo, div_by_zero}); end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++; if ({hi, lo} !== 64'd0) begin fails++; $display("FAIL midrst_hilo got %h exp 0", {hi, lo}); end
        tests++; if ({busy, done, div_by_zero} !== 3'b000) begin fails++; $display("FAIL midrst_flags got %b exp 000", {busy, done, div_by_zero}); end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        tests++; if (dones !== 0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_no_done got dones=%0d busy=%b exp 0 0", dones, busy); end
    endtask

    task automatic test_back_to_back;
        int lat, bb, el_lat;
        logic dz0, ez;
        logic [31:0] eh, el;
        run_op(2'b01, 32'd40, 32'd2, lat, bb, dz0);
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_first_done got %b exp 1", done); end
        run_op(2'b11, 32'd100, 32'd7, lat, bb, dz0);
        model(2'b11, 32'd100, 32'd7, eh, el, ez, el_lat);
        tests++; if ({hi, lo} !== {eh, el}) begin fails++; $display("FAIL b2b_divu got %h exp %h", {hi, lo}, {eh, el}); end
        tests++; if (lat !== el_lat) begin fails++; $display("FAIL b2b_latency got %0d exp %0d", lat, el_lat); end
    endtask

    task automatic test_random;
        int lat, bb, el_lat;
        logic dz0, ez;
        logic [1:0] o;
        logic [31:0] x, y, eh, el;
        for (int n = 0; n < 60; n++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: x = 32'h8000_0000;
                2: y = 32'hFFFF_FFFF;
                3: y = 32'($urandom_range(0, 17));
                4: y = 32'h8000_0000;
                default: ;
            endcase
            model(o, x, y, eh, el, ez, el_lat);
            run_op(o, x, y, lat, bb, dz0);
            tests++; if (hi !== eh) begin fails++; $display("FAIL rnd_hi op=%0d a=%h b=%h got %h exp %h", o, x, y, hi, eh); end
            tests++; if (lo !== el) begin fails++; $display("FAIL rnd_lo op=%0d a=%h b=%h got %h exp %h", o, x, y, lo, el); end
            tests++; if (div_by_zero !== ez) begin fails++; $display("FAIL rnd_dbz op=%0d a=%h b=%h got %b exp %b", o, x, y, div_by_zero, ez); end
            tests++; if (lat !== el_lat || bb !== 0) begin fails++; $display("FAIL rnd_timing op=%0d b=%h got lat=%0d busy_bad=%0d exp lat=%0d busy_bad=0", o, y, lat, bb, el_lat); end
        end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_mthi_mtlo;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
